gate_tt_sequencer: RTL

Controller that exercises the 2-input logic-gate unit (AND/OR/XOR/NAND on 4 result bits) by stepping its two inputs through all four vectors.
- Captures the unit's 4-bit result for each vector into a 16-bit truth table and self-checks it against the golden table.
- Shows one selected gate's column on the LEDs.
- Sits between the board buttons/switches and the gate unit. The gate unit's inputs are driven only by this block.

---
 rtl/gate_tt_pkg.sv | 36 +++
 rtl/btn_cond.sv | 69 ++++++
 rtl/gate_tt_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gate_tt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_tt_pkg
// Description : Shared types and constants for the gate truth-table sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_tt_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Gate column indices inside the truth table / result bus
  localparam logic [1:0] GATE_AND  = 2'd0;
  localparam logic [1:0] GATE_OR   = 2'd1;
  localparam logic [1:0] GATE_XOR  = 2'd2;
  localparam logic [1:0] GATE_NAND = 2'd3;

  // Last input vector of a sweep
  localparam logic [1:0] LAST_VEC = 2'd3;

  // Expected table: {NAND 0x7, XOR 0x6, OR 0xE, AND 0x8}
  localparam logic [15:0] GOLDEN_TT = 16'h76E8;

  // Bit position of (gate, vector) in the 16-bit table
  function automatic logic [3:0] tt_index(input logic [1:0] gate, input logic [1:0] vec);
    return {gate, vec};
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_cond.sv
`default_nettype none
// ============================================================================
// Module      : btn_cond
// Description : Push-button conditioner: 2-FF synchronizer, counting
//               debouncer and one-cycle pulse on the debounced rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_cond #(
  parameter int DB_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_prev_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // Bring the raw button into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // Single-cycle pulse on the debounced 0->1 transition
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_tt_sequencer
// Description : Steps the 2-input gate unit through all four input vectors,
//               captures its 4-bit result into a 16-bit truth table, checks
//               it against the golden table and shows one column on the LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int TICK_DIV  = 125_000_000,
  parameter int DB_CYCLES = 1_250_000,
  parameter int SETTLE    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn_i,
  input  logic       step_btn_i,
  input  logic       auto_en_i,
  input  logic [1:0] gate_sel_i,
  input  logic [3:0] gate_res_i,
  output logic       gate_a_o,
  output logic       gate_b_o,
  output logic [3:0] led_o,
  output logic [1:0] vec_idx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o
);

  localparam int            PW          = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam int            SW          = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_e        state_q;
  logic [1:0]    vec_idx_q;
  logic          gate_a_q;
  logic          gate_b_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [15:0]   table_q;
  logic [15:0]   table_d;
  logic [PW-1:0] presc_q;
  logic [SW-1:0] settle_q;

  logic          start_pulse;
  logic          step_pulse;
  logic          tick;
  logic          advance;
  logic [1:0]    vec_next;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_start_cond (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (start_btn_i),
    .pulse_o (start_pulse)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_step_cond (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (step_btn_i),
    .pulse_o (step_pulse)
  );

  // Advance source follows auto_en combinationally so a mid-WAIT toggle takes effect at once
  assign tick     = (state_q == ST_WAIT) && auto_en_i && (presc_q == PRESC_LAST);
  assign advance  = auto_en_i ? tick : step_pulse;
  assign vec_next = vec_idx_q + 2'd1;

  // Table contents after capturing the current vector's result on all four gates
  always_comb begin
    table_d = table_q;
    for (int g = 0; g < 4; g++) begin
      table_d[tt_index(2'(g), vec_idx_q)] = gate_res_i[g];
    end
  end

  // Sweep sequencer with registered outputs; prescaler cleared unless counting in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_idx_q <= 2'd0;
      gate_a_q  <= 1'b0;
      gate_b_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      table_q   <= '0;
      presc_q   <= '0;
      settle_q  <= '0;
    end else begin
      presc_q <= '0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_pulse) begin
            state_q   <= ST_APPLY;
            vec_idx_q <= 2'd0;
            gate_a_q  <= 1'b0;
            gate_b_q  <= 1'b0;
            table_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            settle_q  <= '0;
          end
        end
        ST_APPLY: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            state_q  <= ST_CAPTURE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_CAPTURE: begin
          table_q <= table_d;
          if (vec_idx_q == LAST_VEC) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (table_d == GOLDEN_TT);
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (advance) begin
            state_q   <= ST_APPLY;
            vec_idx_q <= vec_next;
            gate_a_q  <= vec_next[0];
            gate_b_q  <= vec_next[1];
            settle_q  <= '0;
          end else if (auto_en_i) begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gate_a_o  = gate_a_q;
  assign gate_b_o  = gate_b_q;
  assign vec_idx_o = vec_idx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign led_o     = table_q[{gate_sel_i, 2'b00} +: 4];

endmodule
`default_nettype wire
